// File: rtl/wormhole_switch_buf.sv
// Wormhole demux switch: routes one upstream flit stream onto PORTS buffered outputs.
// A head flit locks the path until its tail; invalid-destination packets are dropped and counted.
module wormhole_switch_buf #(
    parameter int WIDTH    = 32,
    parameter int PORTS    = 4,
    parameter int DEPTH    = 4,
    parameter int DEST_LSB = 0,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         gen_enable,
    input  logic                         req_up_i,
    input  logic [WIDTH-1:0]             Data_up_i,
    output logic                         ack_up_o,
    output logic [PORTS-1:0]             req_dw_o,
    output logic [PORTS-1:0][WIDTH-1:0]  Data_dw_o,
    input  logic [PORTS-1:0]             ack_dw_i,
    input  logic [PORTS-1:0]             Tailpassed_dw_i,
    output logic [CNT_W-1:0]             drop_cnt_o
);

    localparam int DW = $clog2(PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW:0] PORTS_V = PORTS[DW:0];
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b01;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   port_q, port_nxt;
    logic [1:0]      up_type;
    logic [DW-1:0]   dest;
    logic            dest_ok, dest_full, fwd_full;
    logic            wr_do, drop_inc;
    logic [DW-1:0]   wr_sel;
    logic [PORTS-1:0] wr_en, full;

    assign up_type = Data_up_i[WIDTH-1 -: 2];
    assign dest    = Data_up_i[DEST_LSB +: DW];
    assign dest_ok = ({1'b0, dest} < PORTS_V);

    // Decoded lookups avoid indexing past PORTS when the dest field can exceed it
    always_comb begin
        dest_full = 1'b0;
        fwd_full  = 1'b0;
        wr_en     = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (dest == i[DW-1:0])   dest_full = full[i];
            if (port_q == i[DW-1:0]) fwd_full  = full[i];
            if (wr_sel == i[DW-1:0]) wr_en[i]  = wr_do;
        end
    end

    always_comb begin
        ack_up_o  = 1'b0;
        wr_do     = 1'b0;
        wr_sel    = dest;
        drop_inc  = 1'b0;
        state_nxt = state;
        port_nxt  = port_q;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (up_type[1]) begin
                        if (dest_ok) begin
                            ack_up_o = gen_enable & ~dest_full;
                            if (req_up_i && ack_up_o) begin
                                wr_do = 1'b1;
                                if (up_type == T_HEAD) begin
                                    state_nxt = FWD;
                                    port_nxt  = dest;
                                end
                            end
                        end else begin
                            ack_up_o = gen_enable;
                            if (req_up_i && ack_up_o) begin
                                drop_inc = 1'b1;
                                if (up_type == T_HEAD) state_nxt = DROP;
                            end
                        end
                    end else begin
                        // Stray body/tail outside a packet is swallowed
                        ack_up_o = 1'b1;
                    end
                end
                FWD: begin
                    ack_up_o = ~fwd_full;
                    wr_sel   = port_q;
                    if (req_up_i && ack_up_o) begin
                        wr_do = 1'b1;
                        if (up_type == T_TAIL) state_nxt = IDLE;
                    end
                end
                DROP: begin
                    ack_up_o = 1'b1;
                    if (req_up_i && up_type == T_TAIL) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            port_q     <= '0;
            drop_cnt_o <= '0;
        end else begin
            state  <= state_nxt;
            port_q <= port_nxt;
            if (drop_inc && drop_cnt_o != {CNT_W{1'b1}})
                drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_port
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr, rd_ptr;
        logic [AW:0]      count;
        logic             busy, empty, rd_en;

        assign full[g]      = (count == DEPTH_V);
        assign empty        = (count == '0);
        assign Data_dw_o[g] = mem[rd_ptr];
        // A head waits until downstream reports the previous tail has passed
        assign req_dw_o[g]  = ~empty & ~(mem[rd_ptr][WIDTH-1] & busy);
        assign rd_en        = req_dw_o[g] & ack_dw_i[g];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                busy   <= 1'b0;
            end else begin
                if (wr_en[g]) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en)    rd_ptr <= rd_ptr + 1'b1;
                case ({wr_en[g], rd_en})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (rd_en && mem[rd_ptr][WIDTH-1 -: 2] == T_HEAD)
                    busy <= 1'b1;
                else if (Tailpassed_dw_i[g])
                    busy <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en[g]) mem[wr_ptr] <= Data_up_i;
        end
    end

endmodule

// File: tb/tb_wormhole_switch_buf.sv
// Directed bench for wormhole_switch_buf: a 4-port instance for routing behaviour
// and a 3-port instance for invalid-destination dropping and counter saturation.
module tb_wormhole_switch_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, gen_enable;
    logic              req_up, ack_up;
    logic [31:0]       data_up;
    logic [3:0]        req_dw, ack_dw, tp;
    logic [3:0][31:0]  data_dw;
    logic [7:0]        drop_cnt;

    logic              req_up3, ack_up3;
    logic [31:0]       data_up3;
    logic [2:0]        req_dw3, ack_dw3, tp3;
    logic [2:0][31:0]  data_dw3;
    logic [7:0]        drop_cnt3;

    int errors = 0;
    int checks = 0;
    int rxn[4] = '{default: 0};
    int rx3n[3] = '{default: 0};
    logic [31:0] rxd[4][64];

    wormhole_switch_buf #(.WIDTH(32), .PORTS(4), .DEPTH(4), .DEST_LSB(0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .gen_enable(gen_enable),
        .req_up_i(req_up), .Data_up_i(data_up), .ack_up_o(ack_up),
        .req_dw_o(req_dw), .Data_dw_o(data_dw), .ack_dw_i(ack_dw),
        .Tailpassed_dw_i(tp), .drop_cnt_o(drop_cnt));

    wormhole_switch_buf #(.WIDTH(32), .PORTS(3), .DEPTH(4), .DEST_LSB(0), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .gen_enable(gen_enable),
        .req_up_i(req_up3), .Data_up_i(data_up3), .ack_up_o(ack_up3),
        .req_dw_o(req_dw3), .Data_dw_o(data_dw3), .ack_dw_i(ack_dw3),
        .Tailpassed_dw_i(tp3), .drop_cnt_o(drop_cnt3));

    // Log every downstream transfer; sampled mid-cycle, ahead of the edge that commits it
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (req_dw[k] && ack_dw[k]) begin
                if (rxn[k] < 64) rxd[k][rxn[k]] = data_dw[k];
                rxn[k] = rxn[k] + 1;
            end
        for (int k = 0; k < 3; k++)
            if (req_dw3[k] && ack_dw3[k]) rx3n[k] = rx3n[k] + 1;
    end

    function automatic logic [31:0] mk(input logic [1:0] t, input int d, input int pay);
        return {t, pay[27:0], d[1:0]};
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send(input bit u3, input logic [31:0] f, output bit ok);
        int n;
        if (u3) begin req_up3 = 1'b1; data_up3 = f; end
        else    begin req_up  = 1'b1; data_up  = f; end
        #1;
        n = 0;
        while (((u3 ? ack_up3 : ack_up) !== 1'b1) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = ((u3 ? ack_up3 : ack_up) === 1'b1);
        @(posedge clk); #1;
        req_up = 1'b0;
        req_up3 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; gen_enable = 1'b1;
        req_up = 1'b1; data_up = mk(2'b11, 0, 1);
        req_up3 = 1'b0; data_up3 = '0;
        ack_dw = '0; tp = '0; ack_dw3 = '0; tp3 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack_up !== 1'b0) begin errors++; $display("FAIL reset_ack_up: got %b want 0", ack_up); end
        checks++; if (req_dw !== 4'b0000) begin errors++; $display("FAIL reset_req_dw: got %b want 0000", req_dw); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        checks++; if (req_dw3 !== 3'b000) begin errors++; $display("FAIL reset_req_dw3: got %b want 000", req_dw3); end
        reset = 1'b0; req_up = 1'b0;
        tick;
    endtask

    task automatic test_single_flit;
        bit ok;
        logic [31:0] f;
        logic [3:0] exp;
        ack_dw = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            f = mk(2'b11, p, 32'h100 + p);
            exp = 4'b0001 << p;
            send(1'b0, f, ok);
            checks++; if (!ok) begin errors++; $display("FAIL single_ack p%0d: got no ack want ack", p); end
            checks++; if (req_dw !== exp) begin errors++; $display("FAIL single_req p%0d: got %b want %b", p, req_dw, exp); end
            checks++; if (data_dw[p] !== f) begin errors++; $display("FAIL single_data p%0d: got %h want %h", p, data_dw[p], f); end
        end
        tick;
        checks++; if (req_dw !== 4'b0000) begin errors++; $display("FAIL single_drained: got %b want 0000", req_dw); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL single_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_wormhole;
        bit ok, okall;
        int b[4];
        logic [31:0] fl[8];
        for (int k = 0; k < 4; k++) b[k] = rxn[k];
        fl[0] = mk(2'b10, 2, 32'h200);
        for (int i = 1; i < 7; i++) fl[i] = mk(2'b00, 0, 32'h200 + i);
        fl[7] = mk(2'b01, 0, 32'h207);
        ack_dw = 4'b1011;
        okall = 1'b1;
        for (int i = 0; i < 4; i++) begin send(1'b0, fl[i], ok); okall &= ok; end
        req_up = 1'b1; data_up = fl[4];
        #1;
        checks++; if (ack_up !== 1'b0) begin errors++; $display("FAIL worm_full_ack: got %b want 0", ack_up); end
        checks++; if (req_dw !== 4'b0100) begin errors++; $display("FAIL worm_req_hold: got %b want 0100", req_dw); end
        ack_dw = 4'b1111;
        for (int i = 4; i < 8; i++) begin send(1'b0, fl[i], ok); okall &= ok; end
        checks++; if (!okall) begin errors++; $display("FAIL worm_accept: got a missing ack want all acked"); end
        repeat (8) tick;
        checks++; if (rxn[2] - b[2] !== 8) begin errors++; $display("FAIL worm_count: got %0d want 8", rxn[2] - b[2]); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rxd[2][b[2] + i] !== fl[i]) begin
                errors++; $display("FAIL worm_order[%0d]: got %h want %h", i, rxd[2][b[2] + i], fl[i]);
            end
        end
        checks++;
        if (rxn[0] != b[0] || rxn[1] != b[1] || rxn[3] != b[3]) begin
            errors++; $display("FAIL worm_leak: got %0d/%0d/%0d want 0/0/0", rxn[0]-b[0], rxn[1]-b[1], rxn[3]-b[3]);
        end
        tp = 4'b0100; tick; tp = 4'b0000;
    endtask

    task automatic test_tail_passed;
        bit ok, okall;
        int b1;
        logic [31:0] fl[6];
        b1 = rxn[1];
        fl[0] = mk(2'b10, 1, 32'h300); fl[1] = mk(2'b00, 1, 32'h301); fl[2] = mk(2'b01, 1, 32'h302);
        fl[3] = mk(2'b10, 1, 32'h310); fl[4] = mk(2'b00, 1, 32'h311); fl[5] = mk(2'b01, 1, 32'h312);
        ack_dw = 4'b1111;
        okall = 1'b1;
        for (int i = 0; i < 6; i++) begin send(1'b0, fl[i], ok); okall &= ok; end
        checks++; if (!okall) begin errors++; $display("FAIL tp_accept: got a missing ack want all acked"); end
        tick; tick;
        checks++; if (req_dw[1] !== 1'b0) begin errors++; $display("FAIL tp_head_held: got %b want 0", req_dw[1]); end
        checks++; if (rxn[1] - b1 !== 3) begin errors++; $display("FAIL tp_first_pkt: got %0d want 3", rxn[1] - b1); end
        checks++; if (data_dw[1] !== fl[3]) begin errors++; $display("FAIL tp_front: got %h want %h", data_dw[1], fl[3]); end
        tp = 4'b0010; tick; tp = 4'b0000;
        checks++; if (req_dw[1] !== 1'b1) begin errors++; $display("FAIL tp_release: got %b want 1", req_dw[1]); end
        repeat (4) tick;
        checks++; if (rxn[1] - b1 !== 6) begin errors++; $display("FAIL tp_second_pkt: got %0d want 6", rxn[1] - b1); end
        checks++; if (rxd[1][b1 + 3] !== fl[3]) begin errors++; $display("FAIL tp_second_head: got %h want %h", rxd[1][b1 + 3], fl[3]); end
        tp = 4'b0010; tick; tp = 4'b0000;
    endtask

    task automatic test_invalid_dest;
        bit ok, okall;
        int b[3];
        logic [31:0] f;
        for (int k = 0; k < 3; k++) b[k] = rx3n[k];
        ack_dw3 = 3'b111;
        okall = 1'b1;
        send(1'b1, mk(2'b10, 3, 32'h700), ok); okall &= ok;
        send(1'b1, mk(2'b00, 3, 32'h701), ok); okall &= ok;
        send(1'b1, mk(2'b00, 3, 32'h702), ok); okall &= ok;
        send(1'b1, mk(2'b01, 3, 32'h703), ok); okall &= ok;
        checks++; if (!okall) begin errors++; $display("FAIL drop_accept: got a missing ack want all acked"); end
        checks++; if (drop_cnt3 !== 8'd1) begin errors++; $display("FAIL drop_cnt_one: got %0d want 1", drop_cnt3); end
        f = mk(2'b11, 0, 32'h710);
        send(1'b1, f, ok);
        checks++; if (!ok || req_dw3 !== 3'b001) begin errors++; $display("FAIL drop_then_route: got ack=%b req=%b want ack=1 req=001", ok, req_dw3); end
        checks++; if (data_dw3[0] !== f) begin errors++; $display("FAIL drop_then_data: got %h want %h", data_dw3[0], f); end
        tick;
        send(1'b1, mk(2'b00, 0, 32'h720), ok);
        checks++; if (!ok) begin errors++; $display("FAIL stray_ack: got no ack want ack"); end
        tick; tick;
        checks++;
        if (rx3n[0] - b[0] != 1 || rx3n[1] != b[1] || rx3n[2] != b[2]) begin
            errors++; $display("FAIL drop_outputs: got %0d/%0d/%0d want 1/0/0", rx3n[0]-b[0], rx3n[1]-b[1], rx3n[2]-b[2]);
        end
        checks++; if (drop_cnt3 !== 8'd1) begin errors++; $display("FAIL stray_no_count: got %0d want 1", drop_cnt3); end
        okall = 1'b1;
        for (int n = 1; n < 300; n++) begin
            send(1'b1, mk(2'b10, 3, n), ok); okall &= ok;
            send(1'b1, mk(2'b00, 3, n), ok); okall &= ok;
            send(1'b1, mk(2'b00, 3, n), ok); okall &= ok;
            send(1'b1, mk(2'b01, 3, n), ok); okall &= ok;
        end
        checks++; if (!okall) begin errors++; $display("FAIL drop_loop_accept: got a missing ack want all acked"); end
        checks++; if (drop_cnt3 !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt3); end
    endtask

    task automatic test_gen_enable;
        bit ok, okall;
        int b0, b3;
        logic [31:0] f;
        b0 = rxn[0]; b3 = rxn[3];
        ack_dw = 4'b1111;
        okall = 1'b1;
        send(1'b0, mk(2'b10, 0, 32'h500), ok); okall &= ok;
        send(1'b0, mk(2'b00, 0, 32'h501), ok); okall &= ok;
        gen_enable = 1'b0;
        send(1'b0, mk(2'b00, 0, 32'h502), ok); okall &= ok;
        send(1'b0, mk(2'b01, 0, 32'h503), ok); okall &= ok;
        checks++; if (!okall) begin errors++; $display("FAIL gen_midpkt: got a missing ack want all acked"); end
        f = mk(2'b11, 3, 32'h510);
        req_up = 1'b1; data_up = f;
        #1;
        checks++; if (ack_up !== 1'b0) begin errors++; $display("FAIL gen_head_block: got %b want 0", ack_up); end
        tick; tick;
        checks++; if (ack_up !== 1'b0) begin errors++; $display("FAIL gen_head_still: got %b want 0", ack_up); end
        gen_enable = 1'b1;
        #1;
        checks++; if (ack_up !== 1'b1) begin errors++; $display("FAIL gen_head_open: got %b want 1", ack_up); end
        tick;
        req_up = 1'b0;
        checks++; if (req_dw !== 4'b1000 || data_dw[3] !== f) begin errors++; $display("FAIL gen_head_route: got %b/%h want 1000/%h", req_dw, data_dw[3], f); end
        tick; tick;
        checks++; if (rxn[0] - b0 != 4 || rxn[3] - b3 != 1) begin errors++; $display("FAIL gen_counts: got %0d/%0d want 4/1", rxn[0]-b0, rxn[3]-b3); end
        tp = 4'b0001; tick; tp = 4'b0000;
    endtask

    task automatic test_reset_mid_packet;
        bit ok, okall;
        logic [31:0] f;
        ack_dw = 4'b0000;
        okall = 1'b1;
        send(1'b0, mk(2'b10, 1, 32'h600), ok); okall &= ok;
        for (int i = 1; i < 4; i++) begin send(1'b0, mk(2'b00, 1, 32'h600 + i), ok); okall &= ok; end
        checks++; if (!okall) begin errors++; $display("FAIL rst_fill: got a missing ack want all acked"); end
        req_up = 1'b1; data_up = mk(2'b00, 1, 32'h604);
        #1;
        checks++; if (ack_up !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", ack_up); end
        reset = 1'b1;
        #1;
        checks++; if (req_dw !== 4'b0000 || ack_up !== 1'b0) begin errors++; $display("FAIL rst_immediate: got req=%b ack=%b want 0000/0", req_dw, ack_up); end
        checks++; if (drop_cnt3 !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt3); end
        tick;
        reset = 1'b0; req_up = 1'b0; ack_dw = 4'b1111;
        f = mk(2'b11, 3, 32'h610);
        send(1'b0, f, ok);
        checks++; if (!ok || req_dw !== 4'b1000) begin errors++; $display("FAIL rst_reroute: got ack=%b req=%b want 1/1000", ok, req_dw); end
        checks++; if (data_dw[3] !== f) begin errors++; $display("FAIL rst_reroute_data: got %h want %h", data_dw[3], f); end
        tick;
        checks++; if (req_dw !== 4'b0000 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_clean: got %b/%0d want 0000/0", req_dw, drop_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_flit;
        test_wormhole;
        test_tail_passed;
        test_invalid_dest;
        test_gen_enable;
        test_reset_mid_packet;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wormhole_switch_buf.md
Name: wormhole_switch_buf

Overview:
Clocked, parametrised successor to the single-input NoC switch. It demultiplexes one upstream flit stream onto PORTS downstream ports, buffering each port in a DEPTH-entry FIFO. Routing is wormhole: a head flit selects the output, and the path stays locked until the tail flit. Each output holds its next head flit until downstream reports the previous packet's tail has passed. Head flits with an invalid destination are dropped and counted. It sits between an input port module and downstream router stages.

Parameters:
WIDTH, 32, flit width including 2-bit type field [WIDTH-1:WIDTH-2]
PORTS, 4, number of output ports (>=2)
DEPTH, 4, per-output FIFO entries (power of 2, >=2)
DEST_LSB, 0, LSB of destination field in head flit; field width DW=$clog2(PORTS); DEST_LSB+DW <= WIDTH-2
CNT_W, 8, width of drop counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
gen_enable  input  1  1 = new packets may be accepted; 0 = only the in-progress packet completes
req_up_i  input  1  upstream flit valid
Data_up_i  input  WIDTH  upstream flit
ack_up_o  output  1  upstream ready; transfer when req_up_i & ack_up_o at clk edge
req_dw_o  output  PORTS  per-port flit valid
Data_dw_o  output  PORTS x WIDTH  per-port flit (FIFO head)
ack_dw_i  input  PORTS  per-port downstream ready; transfer when req & ack at edge
Tailpassed_dw_i  input  PORTS  per-port pulse: downstream has consumed the previous packet's tail
drop_cnt_o  output  CNT_W  count of dropped packets, saturating

Behaviour:
- Flit type encoding [WIDTH-1:WIDTH-2]: 10 head, 00 body, 01 tail, 11 head+tail (single-flit packet).
- Reset (async assert, sync release): all FIFOs empty, input unlocked, drop mode off, all outstanding flags clear, drop_cnt_o=0, req_dw_o=0, ack_up_o=0 while reset is high.

Input FSM:
- States: IDLE, FWD(port p), DROP.
- IDLE, head flit present, dest < PORTS:
  - ack_up_o = gen_enable & ~full[dest] (combinational on Data_up_i).
  - On transfer: write to FIFO[dest]. Type 10 -> FWD(dest); type 11 -> stay IDLE.
- IDLE, head flit present, dest >= PORTS (possible only when PORTS is not a power of 2):
  - ack_up_o = gen_enable.
  - On transfer: drop_cnt_o += 1, saturating at 2^CNT_W-1. Type 10 -> DROP; type 11 -> stay IDLE.
- IDLE, body/tail flit present (protocol error): ack_up_o=1; flit discarded; counter unchanged.
- FWD(p): ack_up_o = ~full[p], independent of gen_enable. Each transfer writes FIFO[p]; a tail (01) -> IDLE. A head type received in FWD is written as data (no re-route).
- DROP: ack_up_o=1; flits discarded; tail -> IDLE.
- Upstream flit latency: accepted at edge N, visible on req_dw_o/Data_dw_o at edge N+1 at the earliest.

Output side, per port i:
- FIFO is registered; Data_dw_o[i] = oldest entry.
- Flag out_busy[i] is set when a head flit of type 10 transfers downstream. It is cleared by Tailpassed_dw_i[i]=1 at an edge.
- req_dw_o[i] = ~empty[i] & ~(head_at_front[i] & out_busy[i]). Body and tail flits are never blocked by out_busy.
- A type-11 head does not set out_busy.
- Tailpassed_dw_i[i] while out_busy[i]=0 is ignored.
- Set and clear cannot coincide, because a head cannot transfer while busy.

Boundary conditions:
- FIFO full: ack_up_o=0 for that port; no overwrite.
- FIFO write and read in the same cycle when full: not permitted (write is gated by full). Write and read in the same cycle when not full: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH.
- gen_enable falling mid-packet: the packet completes. gen_enable affects only head acceptance in IDLE.
- Reset mid-packet: all buffered flits are discarded immediately.

Test Plan:
- Single-flit packets: 4 heads (type 11) to ports 0..3 with ack_dw_i=1111 -> each appears on the matching req_dw_o exactly one cycle after acceptance, with identical data; drop_cnt_o=0.
- Wormhole lock: head to port 2, 6 bodies, tail, with ack_dw_i[2]=0 and DEPTH=4 -> ack_up_o drops after 4 flits. Raising ack_dw_i[2] drains all 8 flits in order; no flit reaches ports 0, 1 or 3.
- Tail-passed gating: two 3-flit packets to port 1 -> second head is held (req_dw_o[1]=0) after the first tail leaves, until a Tailpassed_dw_i[1] pulse; then it issues on the next cycle.
- Invalid destination (PORTS=3): head dest=3 type 10, 2 bodies, tail -> all 4 flits are acked and discarded; drop_cnt_o=1; a following packet to port 0 routes normally. Repeat 300 times with CNT_W=8 -> counter saturates at 255.
- gen_enable: drop gen_enable mid-packet -> the remaining flits are still accepted; the next head sees ack_up_o=0 until gen_enable=1.
- Reset mid-packet with full FIFOs -> all req_dw_o=0 and drop_cnt_o=0 immediately; after release, the first head is routed from IDLE.
